pe_dbuf: RTL and testbench

Parametrised, weight-stationary processing element for the systolic array, with a double-buffered (shadow/active) weight. One PE sits at each array node. Activations pass left→right, partial sums pass top→bottom, and weights shift down a per-column load chain. A new weight set can be shifted into the shadow registers while the array keeps multiplying with the active weights. A single swap pulse, propagated PE-to-PE, then commits the new set with no pipeline bubble.

---
 rtl/pe_dbuf.sv | 199 +++++++++++++++++++
 tb/tb_pe_dbuf.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pe_dbuf.sv
// pe_dbuf: weight-stationary systolic PE with a shadow/active double-buffered weight.
// Define PE_DBUF_SATURATE_EN for a saturating accumulate with a sticky sat_flag.
module pe_dbuf #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ACC_W-1:0]  sum_in,
    input  logic [WGT_W-1:0]  w_in,
    input  logic              w_load,
    input  logic              w_swap,
    output logic [DATA_W-1:0] data_out,
    output logic [ACC_W-1:0]  mac_out,
    output logic [WGT_W-1:0]  w_out,
    output logic              w_load_out,
    output logic              w_swap_out,
    output logic              active_out,
    output logic              w_valid,
    output logic              sat_flag
);
    localparam int PROD_W = DATA_W + WGT_W;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_LOADED    = 2'd1,
        ST_COMMITTED = 2'd2
    } wstate_e;

    wstate_e           state_q, state_d;
    logic [WGT_W-1:0]  shadow_q, shadow_d;
    logic [WGT_W-1:0]  weight_q, weight_d;
    logic              w_valid_q, w_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [ACC_W-1:0]  mac_out_q, mac_out_d;
    logic              w_load_out_q, w_load_out_d;
    logic              w_swap_out_q, w_swap_out_d;
    logic              active_out_q, active_out_d;
    logic              sat_q, sat_d;
    logic              commit_s;
    logic signed [PROD_W-1:0] prod_s;

`ifdef PE_DBUF_SATURATE_EN
    logic signed [ACC_W:0] sum_wide_s;

    // Signed overflow of the widened sum: the two top bits disagree.
    function automatic logic add_ovf(input logic signed [ACC_W:0] v);
        return v[ACC_W] != v[ACC_W-1];
    endfunction

    // Clamp to the most positive or most negative ACC_W value by sign.
    function automatic logic [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] v);
        logic [ACC_W-1:0] r;
        if (v[ACC_W]) begin
            r = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            r = {1'b0, {(ACC_W-1){1'b1}}};
        end
        return r;
    endfunction
`else
    logic signed [ACC_W-1:0] sum_s;
`endif

    // Weight buffer controller: shadow shift, commit to active, buffer state.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        weight_d  = weight_q;
        w_valid_d = w_valid_q;
        commit_s  = w_swap && (state_q != ST_EMPTY);

        if (w_load) begin
            shadow_d = w_in;
        end else begin
            shadow_d = shadow_q;
        end

        // Commit always takes the pre-load shadow, even with a same-cycle load.
        if (commit_s) begin
            weight_d  = shadow_q;
            w_valid_d = 1'b1;
        end else begin
            weight_d  = weight_q;
            w_valid_d = w_valid_q;
        end

        case (state_q)
            ST_EMPTY: begin
                if (w_load) begin
                    state_d = ST_LOADED;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_LOADED: begin
                if (w_swap && !w_load) begin
                    state_d = ST_COMMITTED;
                end else begin
                    state_d = ST_LOADED;
                end
            end
            ST_COMMITTED: begin
                if (w_load) begin
                    state_d = ST_LOADED;
                end else begin
                    state_d = ST_COMMITTED;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Multiply-accumulate datapath with stall hold.
    always_comb begin
        prod_s = PROD_W'($signed(data_in)) * PROD_W'($signed(weight_q));
`ifdef PE_DBUF_SATURATE_EN
        sum_wide_s = (ACC_W+1)'($signed(sum_in)) + (ACC_W+1)'(prod_s);
`else
        sum_s = $signed(sum_in) + ACC_W'(prod_s);
`endif
        data_out_d = data_out_q;
        mac_out_d  = mac_out_q;
        sat_d      = sat_q;

        if (active) begin
            data_out_d = data_in;
`ifdef PE_DBUF_SATURATE_EN
            if (add_ovf(sum_wide_s)) begin
                mac_out_d = sat_clamp(sum_wide_s);
                sat_d     = 1'b1;
            end else begin
                mac_out_d = sum_wide_s[ACC_W-1:0];
                sat_d     = sat_q;
            end
`else
            mac_out_d = sum_s;
            sat_d     = 1'b0;
`endif
        end else begin
            data_out_d = data_out_q;
            mac_out_d  = mac_out_q;
`ifdef PE_DBUF_SATURATE_EN
            sat_d      = sat_q;
`else
            sat_d      = 1'b0;
`endif
        end
    end

    // Control pass-through to the next PE, unconditional one-cycle delay.
    always_comb begin
        active_out_d = active;
        w_load_out_d = w_load;
        w_swap_out_d = w_swap;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            shadow_q     <= {WGT_W{1'b0}};
            weight_q     <= {WGT_W{1'b0}};
            w_valid_q    <= 1'b0;
            data_out_q   <= {DATA_W{1'b0}};
            mac_out_q    <= {ACC_W{1'b0}};
            active_out_q <= 1'b0;
            w_load_out_q <= 1'b0;
            w_swap_out_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            weight_q     <= weight_d;
            w_valid_q    <= w_valid_d;
            data_out_q   <= data_out_d;
            mac_out_q    <= mac_out_d;
            active_out_q <= active_out_d;
            w_load_out_q <= w_load_out_d;
            w_swap_out_q <= w_swap_out_d;
            sat_q        <= sat_d;
        end
    end

    assign data_out   = data_out_q;
    assign mac_out    = mac_out_q;
    assign w_out      = shadow_q;
    assign w_load_out = w_load_out_q;
    assign w_swap_out = w_swap_out_q;
    assign active_out = active_out_q;
    assign w_valid    = w_valid_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_pe_dbuf.sv
// tb_pe_dbuf: directed scoreboard bench for pe_dbuf (default widths 8/8/16).
module tb_pe_dbuf;
    logic        clk;
    logic        rst;
    logic        active;
    logic [7:0]  data_in;
    logic [15:0] sum_in;
    logic [7:0]  w_in;
    logic        w_load;
    logic        w_swap;
    logic [7:0]  data_out;
    logic [15:0] mac_out;
    logic [7:0]  w_out;
    logic        w_load_out;
    logic        w_swap_out;
    logic        active_out;
    logic        w_valid;
    logic        sat_flag;

`ifdef PE_DBUF_SATURATE_EN
    localparam int SAT_POS = 32767;
    localparam int SAT_NEG = -32768;
    localparam int SAT_F   = 1;
`else
    localparam int SAT_POS = -16640;
    localparam int SAT_NEG = 16512;
    localparam int SAT_F   = 0;
`endif

    typedef struct packed {
        logic [7:0]  d;
        logic [15:0] m;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    pe_dbuf #(.DATA_W(8), .WGT_W(8), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .active(active), .data_in(data_in), .sum_in(sum_in),
        .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .data_out(data_out),
        .mac_out(mac_out), .w_out(w_out), .w_load_out(w_load_out),
        .w_swap_out(w_swap_out), .active_out(active_out), .w_valid(w_valid),
        .sat_flag(sat_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle; when active, queue the hand-computed response.
    task automatic step(input logic a, input int d, input int s, input int w,
                        input logic ld, input logic sw, input int ed, input int em);
        exp_t e;
        active  = a;
        data_in = d[7:0];
        sum_in  = s[15:0];
        w_in    = w[7:0];
        w_load  = ld;
        w_swap  = sw;
        if (a) begin
            e.d = ed[7:0];
            e.m = em[15:0];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every registered compute result is checked against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && active_out) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got mac_out=%0d with empty queue", $signed(mac_out));
            end else begin
                e = sb.pop_front();
                total++;
                if (data_out != e.d) begin
                    bad++;
                    $display("FAIL data_out: got %0d expected %0d", $signed(data_out), $signed(e.d));
                end
                total++;
                if (mac_out != e.m) begin
                    bad++;
                    $display("FAIL mac_out: got %0d expected %0d", $signed(mac_out), $signed(e.m));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; active = 1'b0; data_in = 8'd0; sum_in = 16'd0;
        w_in = 8'd0; w_load = 1'b0; w_swap = 1'b0;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_mac_out", int'(mac_out), 0);
        chk("rst_w_out", int'(w_out), 0);
        chk("rst_w_valid", int'(w_valid), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        chk("rst_active_out", int'(active_out), 0);

        // Basic MAC: load 3, swap, 3 * -5 + 100 = 85
        step(1'b0, 0, 0, 3, 1'b1, 1'b0, 0, 0);
        chk("load_w_out", int'(w_out), 3);
        chk("w_load_out", int'(w_load_out), 1);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
        chk("swap_w_valid", int'(w_valid), 1);
        chk("w_swap_out", int'(w_swap_out), 1);
        step(1'b1, -5, 100, 0, 1'b0, 1'b0, -5, 85);

        // Double buffer: load 7 in background, swap takes effect one cycle later
        step(1'b1, 2, 0, 7, 1'b1, 1'b0, 2, 6);
        step(1'b1, 2, 0, 0, 1'b0, 1'b0, 2, 6);
        step(1'b1, 2, 0, 0, 1'b0, 1'b1, 2, 6);
        step(1'b1, 2, 0, 0, 1'b0, 1'b0, 2, 14);

        // Simultaneous load and swap: weight gets old shadow 4, shadow gets 9
        step(1'b0, 0, 0, 1, 1'b1, 1'b0, 0, 0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
        step(1'b0, 0, 0, 4, 1'b1, 1'b0, 0, 0);
        step(1'b1, 1, 0, 0, 1'b0, 1'b0, 1, 1);
        step(1'b0, 0, 0, 9, 1'b1, 1'b1, 0, 0);
        chk("simul_w_out", int'(w_out), 9);
        step(1'b1, 1, 0, 0, 1'b0, 1'b0, 1, 4);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
        step(1'b1, 1, 0, 0, 1'b0, 1'b0, 1, 9);

        // Stall: outputs frozen at data_out=1, mac_out=9
        step(1'b0, 50, 77, 0, 1'b0, 1'b0, 0, 0);
        chk("stall_active_out", int'(active_out), 0);
        chk("stall1_data", int'($signed(data_out)), 1);
        chk("stall1_mac", int'($signed(mac_out)), 9);
        step(1'b0, -3, -200, 0, 1'b0, 1'b0, 0, 0);
        chk("stall2_data", int'($signed(data_out)), 1);
        chk("stall2_mac", int'($signed(mac_out)), 9);
        step(1'b0, 99, 1234, 0, 1'b0, 1'b0, 0, 0);
        chk("stall3_data", int'($signed(data_out)), 1);
        chk("stall3_mac", int'($signed(mac_out)), 9);

        // Overflow: 127*127+32767 and -128*127-32768
        step(1'b0, 0, 0, 127, 1'b1, 1'b0, 0, 0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
        step(1'b1, 127, 32767, 0, 1'b0, 1'b0, 127, SAT_POS);
        chk("sat_flag_pos", int'(sat_flag), SAT_F);
        step(1'b1, -128, -32768, 0, 1'b0, 1'b0, -128, SAT_NEG);
        chk("sat_flag_neg", int'(sat_flag), SAT_F);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        chk("sat_flag_sticky", int'(sat_flag), SAT_F);

        // Async reset mid-operation with mac_out=0x1234 and w_valid=1
        step(1'b0, 0, 0, 1, 1'b1, 1'b0, 0, 0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
        step(1'b1, 1, 4659, 0, 1'b0, 1'b0, 1, 4660);
        @(negedge clk);
        #1;
        active = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_mac", int'(mac_out), 0);
        chk("async_rst_data", int'(data_out), 0);
        chk("async_rst_w_valid", int'(w_valid), 0);
        chk("async_rst_w_out", int'(w_out), 0);
        chk("async_rst_sat", int'(sat_flag), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
        chk("empty_swap_w_valid", int'(w_valid), 0);
        step(1'b1, 5, 3, 0, 1'b0, 1'b0, 5, 3);

        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        chk("queue_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
